// File: rtl/ir_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// ir_fetch_stage_if
// Groups the fetch stage's control, memory and result signals into one
// bundle. The fetch stage uses the "master" view (it issues memory reads and
// produces IR/SEIMM). Control logic, instruction memory or a testbench uses
// the "slave" view.
//
// Signals (all DW bits wide unless noted):
//   PC         current program counter, sampled when a fetch is accepted
//   FETCH      (1b) fetch request, looked at only while idle
//   FLUSH      (1b) abort an outstanding fetch / drop a same-cycle request
//   MEM_ADDR   instruction memory address (captured PC)
//   MEM_RD     (1b) read request, high for the whole wait period
//   MEM_RDATA  instruction word returned by memory
//   MEM_RDY    (1b) memory completion strobe
//   IR         instruction register
//   SEIMM      sign-extended immediate taken from the low bits of IR
//   IR_VALID   (1b) one-cycle pulse after IR is loaded
//   BUSY       (1b) high while a fetch is outstanding
//   FETCH_CNT  completed-fetch counter (wraps)
//   FETCH_ERR  (1b) sticky fetch timeout flag
// ---------------------------------------------------------------------------
interface ir_fetch_stage_if #(
  parameter int DW = 16
);
  logic [DW-1:0] PC;
  logic          FETCH;
  logic          FLUSH;
  logic [DW-1:0] MEM_ADDR;
  logic          MEM_RD;
  logic [DW-1:0] MEM_RDATA;
  logic          MEM_RDY;
  logic [DW-1:0] IR;
  logic [DW-1:0] SEIMM;
  logic          IR_VALID;
  logic          BUSY;
  logic [DW-1:0] FETCH_CNT;
  logic          FETCH_ERR;

  // Fetch stage side: consumes requests and memory data, drives results.
  modport master (
    input  PC, FETCH, FLUSH, MEM_RDATA, MEM_RDY,
    output MEM_ADDR, MEM_RD, IR, SEIMM, IR_VALID, BUSY, FETCH_CNT, FETCH_ERR
  );

  // Environment side: control unit plus instruction memory.
  modport slave (
    output PC, FETCH, FLUSH, MEM_RDATA, MEM_RDY,
    input  MEM_ADDR, MEM_RD, IR, SEIMM, IR_VALID, BUSY, FETCH_CNT, FETCH_ERR
  );
endinterface

// File: rtl/ir_fetch_stage.sv
// ---------------------------------------------------------------------------
// ir_fetch_stage
// Instruction-fetch stage sitting directly upstream of the PC adder/mux.
// When a fetch request is accepted, the stage captures PC and holds a read
// request to instruction memory until the memory answers or the fetch is
// flushed. The returned word is latched into IR. SEIMM is the sign-extended
// low IMM_W bits of IR. A wrapping counter records completed fetches for
// debug.
//
// Ports:
//   CLK    rising-edge clock for all state
//   RESET  synchronous, active-high reset
//   bus    ir_fetch_stage_if.master (PC/FETCH/FLUSH in, memory handshake,
//          IR/SEIMM/IR_VALID/BUSY/FETCH_CNT/FETCH_ERR out)
//
// Parameters:
//   DW              data/instruction/address width
//   IMM_W           immediate field width. Must be less than DW.
//   TIMEOUT_CYCLES  wait-cycle limit. Used only when FETCH_TIMEOUT_EN is set.
//
// Optional feature, selected by the macro FETCH_TIMEOUT_EN:
//   When the macro is defined, a fetch that stays unanswered for
//   TIMEOUT_CYCLES wait cycles is retired with a NOP in IR. IR_VALID still
//   pulses, and the sticky FETCH_ERR flag is set. When the macro is not
//   defined, a fetch waits indefinitely and FETCH_ERR is tied low.
// ---------------------------------------------------------------------------
module ir_fetch_stage #(
  parameter int DW             = 16,
  parameter int IMM_W          = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic             CLK,
  input  logic             RESET,
  ir_fetch_stage_if.master bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [DW-1:0] CNT_ONE = {{(DW-1){1'b0}}, 1'b1};

  // Replicate the immediate's top bit into the upper DW-IMM_W bits.
  function automatic logic [DW-1:0] sign_extend(input logic [IMM_W-1:0] imm);
    sign_extend = {{(DW-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

  state_t        state_r;
  logic [DW-1:0] addr_r;
  logic [DW-1:0] ir_r;
  logic [DW-1:0] fetch_cnt_r;
  logic          ir_valid_r;
  logic          mem_rd_r;
  logic          busy_r;

`ifdef FETCH_TIMEOUT_EN
  localparam int             WCW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);
  localparam logic [WCW-1:0] WAIT_ONE  = {{(WCW-1){1'b0}}, 1'b1};

  logic [WCW-1:0] wait_cnt_r;
  logic           fetch_err_r;
`endif

  // Fetch FSM. State, IR, counter and handshake outputs are all registered here.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      addr_r      <= {DW{1'b0}};
      ir_r        <= {DW{1'b0}};
      fetch_cnt_r <= {DW{1'b0}};
      ir_valid_r  <= 1'b0;
      mem_rd_r    <= 1'b0;
      busy_r      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_r  <= {WCW{1'b0}};
      fetch_err_r <= 1'b0;
`endif
    end else begin
      // IR_VALID is a single-cycle pulse unless a completion re-asserts it.
      ir_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // FLUSH wins over a same-cycle request; MEM_RDY is ignored here.
          if (bus.FETCH && !bus.FLUSH) begin
            addr_r   <= bus.PC;
            state_r  <= ST_WAIT;
            mem_rd_r <= 1'b1;
            busy_r   <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_r <= {WCW{1'b0}};
`endif
          end else begin
            state_r  <= ST_IDLE;
            mem_rd_r <= 1'b0;
            busy_r   <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (bus.FLUSH) begin
            // Abort: IR, counter and IR_VALID are left alone, even if the
            // memory answers in this same cycle.
            state_r  <= ST_IDLE;
            mem_rd_r <= 1'b0;
            busy_r   <= 1'b0;
          end else if (bus.MEM_RDY) begin
            ir_r        <= bus.MEM_RDATA;
            ir_valid_r  <= 1'b1;
            fetch_cnt_r <= fetch_cnt_r + CNT_ONE;
            state_r     <= ST_IDLE;
            mem_rd_r    <= 1'b0;
            busy_r      <= 1'b0;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt_r == WAIT_LAST) begin
            // This is the last permitted wait cycle, with no answer from
            // memory. Retire the fetch as a NOP and flag the error.
            ir_r        <= {DW{1'b0}};
            ir_valid_r  <= 1'b1;
            fetch_err_r <= 1'b1;
            state_r     <= ST_IDLE;
            mem_rd_r    <= 1'b0;
            busy_r      <= 1'b0;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
            state_r    <= ST_WAIT;
            mem_rd_r   <= 1'b1;
            busy_r     <= 1'b1;
          end
`else
          else begin
            state_r  <= ST_WAIT;
            mem_rd_r <= 1'b1;
            busy_r   <= 1'b1;
          end
`endif
        end
        default: begin
          state_r  <= ST_IDLE;
          mem_rd_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  // The memory address always comes from the captured PC, never live from PC.
  assign bus.MEM_ADDR  = addr_r;
  assign bus.MEM_RD    = mem_rd_r;
  assign bus.BUSY      = busy_r;
  assign bus.IR        = ir_r;
  assign bus.IR_VALID  = ir_valid_r;
  assign bus.FETCH_CNT = fetch_cnt_r;
  assign bus.SEIMM     = sign_extend(ir_r[IMM_W-1:0]);

`ifdef FETCH_TIMEOUT_EN
  assign bus.FETCH_ERR = fetch_err_r;
`else
  assign bus.FETCH_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ir_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_ir_fetch_stage
// Directed plus randomized transactions for ir_fetch_stage. Expected values
// come from a transaction-level model: a fetch either completes, which loads
// its data and bumps the count, or is flushed, which changes nothing. A
// second, narrow instance (DW=8) exercises counter wrap in few cycles.
// ---------------------------------------------------------------------------
module tb_ir_fetch_stage;
  localparam int TO = 15;

  logic CLK = 1'b0;
  logic RESET = 1'b0;

  ir_fetch_stage_if #(.DW(16)) b16 ();
  ir_fetch_stage_if #(.DW(8))  b8 ();

  ir_fetch_stage #(.DW(16), .IMM_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET), .bus(b16)
  );

  ir_fetch_stage #(.DW(8), .IMM_W(4), .TIMEOUT_CYCLES(TO)) dut8 (
    .CLK(CLK), .RESET(RESET), .bus(b8)
  );

  always #5 CLK = ~CLK;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // Reference model state (16-bit instance)
  logic [15:0] exp_ir   = 16'h0000;
  logic [15:0] exp_cnt  = 16'h0000;
  logic [15:0] exp_addr = 16'h0000;
  logic        exp_err  = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sign-extend the low byte arithmetically, as a signed 8-bit number.
  function automatic logic [15:0] model_seimm(input logic [15:0] ir);
    int v;
    v = int'(ir[7:0]);
    if (v > 127) v = v - 256;
    return 16'(v);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_step();
    b16.FETCH = 1'b0;
    b16.PC = 16'($urandom);
    step();
    chk("idle_valid", {15'h0, b16.IR_VALID}, 16'h0000);
    chk("idle_busy", {15'h0, b16.BUSY}, 16'h0000);
    chk("idle_addr", b16.MEM_ADDR, exp_addr);
  endtask

  // One fetch transaction. The memory answers after d empty wait cycles.
  // fl: 0 = normal completion, 1 = FLUSH together with MEM_RDY, 2 = FLUSH only.
  task automatic fetch(input logic [15:0] pc, input logic [15:0] data,
                       input int d, input int fl, output int busy_cycles);
    busy_cycles = 0;
    b16.PC = pc;
    b16.FETCH = 1'b1;
    step();
    b16.FETCH = 1'b0;
    exp_addr = pc;
    chk("acc_valid", {15'h0, b16.IR_VALID}, 16'h0000);
    chk("acc_rd", {15'h0, b16.MEM_RD}, 16'h0001);
    chk("acc_addr", b16.MEM_ADDR, pc);
    if (b16.BUSY === 1'b1) busy_cycles++;
    for (int i = 0; i < d; i++) begin
      b16.PC = 16'($urandom);
      b16.FETCH = 1'($urandom);
      b16.MEM_RDATA = 16'($urandom);
      step();
      chk("wait_addr", b16.MEM_ADDR, pc);
      chk("wait_valid", {15'h0, b16.IR_VALID}, 16'h0000);
      if (b16.BUSY === 1'b1) busy_cycles++;
    end
    b16.FETCH = 1'b0;
    b16.MEM_RDATA = data;
    b16.MEM_RDY = (fl != 2);
    b16.FLUSH = (fl != 0);
    step();
    b16.MEM_RDY = 1'b0;
    b16.FLUSH = 1'b0;
    if (fl == 0) begin
      exp_ir = data;
      exp_cnt = exp_cnt + 16'd1;
    end
    chk("done_valid", {15'h0, b16.IR_VALID}, (fl == 0) ? 16'h0001 : 16'h0000);
    chk("done_ir", b16.IR, exp_ir);
    chk("done_seimm", b16.SEIMM, model_seimm(exp_ir));
    chk("done_cnt", b16.FETCH_CNT, exp_cnt);
    chk("done_busy", {15'h0, b16.BUSY}, 16'h0000);
    chk("done_rd", {15'h0, b16.MEM_RD}, 16'h0000);
    chk("done_err", {15'h0, b16.FETCH_ERR}, {15'h0, exp_err});
  endtask

  initial begin
    int bc;
    int d;
    int fl;
    logic [15:0] hold_ir;
    logic [15:0] hold_cnt;

    b16.PC = 16'h0000; b16.FETCH = 1'b0; b16.FLUSH = 1'b0;
    b16.MEM_RDATA = 16'h0000; b16.MEM_RDY = 1'b0;
    b8.PC = 8'h00; b8.FETCH = 1'b0; b8.FLUSH = 1'b0;
    b8.MEM_RDATA = 8'h00; b8.MEM_RDY = 1'b0;

    // Reset
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("rst_ir", b16.IR, 16'h0000);
    chk("rst_seimm", b16.SEIMM, 16'h0000);
    chk("rst_cnt", b16.FETCH_CNT, 16'h0000);
    chk("rst_rd", {15'h0, b16.MEM_RD}, 16'h0000);
    chk("rst_busy", {15'h0, b16.BUSY}, 16'h0000);
    chk("rst_valid", {15'h0, b16.IR_VALID}, 16'h0000);
    chk("rst_addr", b16.MEM_ADDR, 16'h0000);
    chk("rst_err", {15'h0, b16.FETCH_ERR}, 16'h0000);

    // Basic fetch, with the answer in the first wait cycle (2-cycle latency)
    fetch(16'h0040, 16'h12F6, 0, 0, bc);
    chk("basic_ir", b16.IR, 16'h12F6);
    chk("basic_seimm", b16.SEIMM, 16'hFFF6);
    chk("basic_cnt", b16.FETCH_CNT, 16'h0001);
    idle_step();

    // Slow memory: PC wanders during the wait, and busy lasts 4 cycles
    fetch(16'h0100, 16'h3046, 3, 0, bc);
    chk("slow_busy_cycles", 16'(bc), 16'd4);
    chk("slow_seimm", b16.SEIMM, 16'h0046);
    b16.PC = 16'h0200;
    idle_step();

    // FLUSH together with MEM_RDY: nothing is retired
    fetch(16'h0010, 16'hBEEF, 1, 1, bc);
    chk("flush_ir_kept", b16.IR, 16'h3046);
    fetch(16'h0020, 16'h0081, 0, 0, bc);
    chk("after_flush_seimm", b16.SEIMM, 16'hFF81);

    // While idle, FLUSH drops a same-cycle FETCH and MEM_RDY is ignored
    b16.FETCH = 1'b1; b16.FLUSH = 1'b1; b16.PC = 16'h0999;
    step();
    b16.FETCH = 1'b0; b16.FLUSH = 1'b0;
    chk("idle_flush_busy", {15'h0, b16.BUSY}, 16'h0000);
    chk("idle_flush_addr", b16.MEM_ADDR, exp_addr);
    b16.MEM_RDY = 1'b1; b16.MEM_RDATA = 16'hCAFE;
    step();
    b16.MEM_RDY = 1'b0;
    chk("idle_rdy_ir", b16.IR, exp_ir);
    chk("idle_rdy_valid", {15'h0, b16.IR_VALID}, 16'h0000);
    chk("idle_rdy_cnt", b16.FETCH_CNT, exp_cnt);

    // Randomized transactions, sometimes back-to-back
    for (int n = 0; n < 40; n++) begin
      d = $urandom_range(0, 5);
      fl = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
      fetch(16'($urandom), 16'($urandom), d, fl, bc);
      chk("rnd_busy_cycles", 16'(bc), 16'(d + 1));
      if ($urandom_range(0, 1) == 1) idle_step();
    end

    // Reset in the middle of a wait; a later MEM_RDY must be ignored
    b16.PC = 16'h0555; b16.FETCH = 1'b1;
    step();
    b16.FETCH = 1'b0;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    exp_ir = 16'h0000; exp_cnt = 16'h0000; exp_addr = 16'h0000; exp_err = 1'b0;
    chk("midrst_busy", {15'h0, b16.BUSY}, 16'h0000);
    b16.MEM_RDY = 1'b1; b16.MEM_RDATA = 16'h7777;
    step();
    b16.MEM_RDY = 1'b0;
    chk("midrst_ir", b16.IR, 16'h0000);
    chk("midrst_valid", {15'h0, b16.IR_VALID}, 16'h0000);
    chk("midrst_cnt", b16.FETCH_CNT, 16'h0000);
    chk("midrst_rd", {15'h0, b16.MEM_RD}, 16'h0000);
    chk("midrst_addr", b16.MEM_ADDR, 16'h0000);

    // Counter wrap on the narrow instance: every fetch takes 2 edges
    b8.MEM_RDATA = 8'hA5; b8.FETCH = 1'b1; b8.MEM_RDY = 1'b1;
    repeat (2 * 255) step();
    chk("wrap8_full", {8'h00, b8.FETCH_CNT}, 16'h00FF);
    step();
    step();
    b8.FETCH = 1'b0; b8.MEM_RDY = 1'b0;
    chk("wrap8_zero", {8'h00, b8.FETCH_CNT}, 16'h0000);
    chk("wrap8_valid", {15'h0, b8.IR_VALID}, 16'h0001);
    chk("wrap8_seimm", {8'h00, b8.SEIMM}, 16'h0005);

`ifdef FETCH_TIMEOUT_EN
    // Timeout: after TO unanswered wait cycles, a NOP is retired and the error is flagged
    fetch(16'h0300, 16'h5A5A, 0, 0, bc);
    hold_ir = exp_ir;
    hold_cnt = exp_cnt;
    b16.PC = 16'h0300; b16.FETCH = 1'b1;
    step();
    b16.FETCH = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      step();
      if (i == TO - 2) begin
        chk("to_pre_valid", {15'h0, b16.IR_VALID}, 16'h0000);
        chk("to_pre_busy", {15'h0, b16.BUSY}, 16'h0001);
        chk("to_pre_ir", b16.IR, hold_ir);
      end
    end
    step();
    exp_ir = 16'h0000; exp_err = 1'b1; exp_addr = 16'h0300;
    chk("to_valid", {15'h0, b16.IR_VALID}, 16'h0001);
    chk("to_ir", b16.IR, 16'h0000);
    chk("to_err", {15'h0, b16.FETCH_ERR}, 16'h0001);
    chk("to_cnt", b16.FETCH_CNT, hold_cnt);
    chk("to_busy", {15'h0, b16.BUSY}, 16'h0000);
    fetch(16'h0400, 16'h1111, 2, 0, bc);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("to_err_cleared", {15'h0, b16.FETCH_ERR}, 16'h0000);
`else
    hold_ir = 16'h0000;
    hold_cnt = 16'h0000;
    // Without the timeout, a long wait just keeps waiting with no error
    fetch(16'h0300, 16'h5A5A, TO + 4, 0, bc);
    chk("long_wait_busy", 16'(bc), 16'(TO + 5));
    chk("long_wait_err", {15'h0, b16.FETCH_ERR}, 16'h0000);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ir_fetch_stage.md
Name: ir_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the PC adder/mux stage.
- Takes the current PC and issues a read handshake to instruction memory.
- Latches the returned word into IR and produces the sign-extended immediate SEIMM.
- Both IR and SEIMM feed the PC adder/mux stage and the datapath.
- Also keeps a count of completed fetches for debug.

Parameters:
- DW, 16, data/instruction/address width
- IMM_W, 8, width of the immediate field IR[IMM_W-1:0] that is sign-extended to DW bits
- TIMEOUT_CYCLES, 15, WAIT-state cycle limit; used only when FETCH_TIMEOUT_EN is defined

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- PC  in  DW  current program counter (the PC register value)
- FETCH  in  1  fetch request from control; sampled only in IDLE
- FLUSH  in  1  abort an outstanding fetch (e.g. jump taken)
- MEM_ADDR  out  DW  instruction memory address
- MEM_RD  out  1  read request; held high for the whole WAIT state
- MEM_RDATA  in  DW  instruction word; valid when MEM_RDY=1
- MEM_RDY  in  1  memory completion strobe
- IR  out  DW  instruction register
- SEIMM  out  DW  sign-extended IR[IMM_W-1:0]; combinational from IR
- IR_VALID  out  1  one-cycle pulse: IR was just loaded
- BUSY  out  1  high in the WAIT state
- FETCH_CNT  out  DW  completed-fetch counter
- FETCH_ERR  out  1  sticky timeout flag; constant 0 without FETCH_TIMEOUT_EN

Behaviour:
- Reset (RESET=1 at a rising edge, in any state, including mid-WAIT):
  - state=IDLE, captured address=0
  - IR=0, IR_VALID=0, FETCH_CNT=0, FETCH_ERR=0
  - MEM_RD=0 and BUSY=0 from the next cycle on
  - A MEM_RDY arriving after reset is ignored.
- FSM states: IDLE, WAIT.
- IDLE:
  - MEM_RD=0, BUSY=0, MEM_ADDR = captured address (stable, not PC).
  - FETCH=1 and FLUSH=0 at an edge: capture PC into the address register; go to WAIT.
- WAIT:
  - MEM_RD=1, BUSY=1, MEM_ADDR = captured address; PC changes are ignored.
  - FETCH is ignored.
- Completion: edge in WAIT with MEM_RDY=1 and FLUSH=0:
  - IR <= MEM_RDATA; IR_VALID <= 1 for exactly one cycle
  - FETCH_CNT <= FETCH_CNT+1, wrapping modulo 2^DW (0xFFFF -> 0x0000)
  - state <= IDLE
- Latency:
  - MEM_RD rises the cycle after FETCH is accepted.
  - MEM_RDY may arrive in that first WAIT cycle.
  - Minimum FETCH-to-IR_VALID latency is 2 cycles.
  - Back-to-back: FETCH asserted in the IR_VALID cycle is accepted (the FSM is in IDLE).
- FLUSH:
  - Priority over everything except RESET.
  - In WAIT: return to IDLE, IR unchanged, no IR_VALID, no count increment, even if MEM_RDY=1 in the same cycle.
  - In IDLE: a same-cycle FETCH is dropped.
- MEM_RDY outside WAIT: ignored.
- IR holds its value until the next completion or reset.
- SEIMM = {(DW-IMM_W){IR[IMM_W-1]}, IR[IMM_W-1:0]}, recomputed whenever IR changes.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without MEM_RDY.
  - If it reaches TIMEOUT_CYCLES with no MEM_RDY: FETCH_ERR <= 1 (sticky until RESET), IR <= 0 (NOP), IR_VALID pulses, FETCH_CNT is not incremented, state <= IDLE.
  - MEM_RDY arriving in the expiry cycle wins; it is a normal completion.
  - FLUSH in the expiry cycle wins over both.
- Undefined: no counter, WAIT lasts until MEM_RDY or FLUSH, FETCH_ERR tied to 0.

Test Plan:
- Reset check: RESET=1 for 1 edge, then release -> IR=0x0000, SEIMM=0x0000, FETCH_CNT=0, MEM_RD=0, BUSY=0, IR_VALID=0.
- Basic fetch: PC=0x0040, FETCH=1 for 1 cycle; memory answers MEM_RDY=1 in the first WAIT cycle with MEM_RDATA=0x12F6 -> MEM_ADDR=0x0040 while MEM_RD=1; IR=0x12F6; SEIMM=0xFFF6; IR_VALID high exactly 1 cycle, 2 cycles after FETCH; FETCH_CNT=1.
- Slow memory and address stability: PC=0x0100, FETCH; change PC to 0x0200 during WAIT; MEM_RDY after 4 cycles with 0x3046 -> MEM_ADDR stays 0x0100; BUSY high 4 cycles; IR=0x3046; SEIMM=0x0046.
- Flush vs ready: FETCH at PC=0x0010; FLUSH=1 and MEM_RDY=1 in the same cycle with data 0xBEEF -> IR keeps its old value, no IR_VALID, FETCH_CNT unchanged, FSM in IDLE; a following FETCH works normally.
- Reset mid-operation and wrap: RESET during WAIT -> IDLE, late MEM_RDY ignored, IR=0. Separately, preload 0xFFFF completions -> the next completion gives FETCH_CNT=0x0000.
- Timeout (FETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=15): FETCH with no MEM_RDY -> after 15 WAIT cycles FETCH_ERR=1, IR=0x0000, IR_VALID pulse, FETCH_CNT unchanged; FETCH_ERR stays 1 until RESET.
